mem_fetch_ctrl: RTL

- Sequential read initiator for the synchronous word memory; drives its `wr_en`/`rd_en`/`data_in`/`r_addr` and consumes its `data_out`.
- Sits between that memory and the downstream decode stage.
- Walks a byte-addressed program counter and tolerates the memory's fixed 1-cycle read latency.
- Delivers words over a valid/ready stream with redirect, stop, and an optional preload path.

---
 rtl/mem_fetch_ctrl_pkg.sv | 21 ++
 rtl/mem_fetch_ctrl_if.sv | 34 +++
 rtl/mem_fetch_ctrl_skid_buf.sv | 73 +++++++
 rtl/mem_fetch_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mem_fetch_ctrl_pkg.sv
// fetch_pkg: shared types and constants for mem_fetch_ctrl.
//   fetch_state_e  : controller states (IDLE, FETCH, DRAIN, LOAD)
//   PC_STEP        : byte increment between consecutive words
//   pc_wrap_limit(): last valid byte address for a memory of the given depth
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    LOAD  = 2'd3
  } fetch_state_e;

  localparam int unsigned PC_STEP = 4;

  // Byte address of the last word; the next step from here wraps to 0.
  function automatic int unsigned pc_wrap_limit(input int unsigned mem_depth);
    return (mem_depth - 1) * PC_STEP;
  endfunction

endpackage

// File: rtl/mem_fetch_ctrl_if.sv
// mem_fetch_ctrl_if: memory bus plus instruction stream of mem_fetch_ctrl.
//   Memory side : mem_wr_en, mem_rd_en, mem_data_in, mem_addr (to memory),
//                 mem_data_out (from memory, 1-cycle read latency)
//   Stream side : instr_valid, instr_data, instr_pc (to decode),
//                 instr_ready (from decode)
//   master modport: the fetch controller; slave modport: memory + decode.
interface mem_fetch_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 7
);
  logic                  mem_wr_en;
  logic                  mem_rd_en;
  logic [DATA_WIDTH-1:0] mem_data_in;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data_out;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [DATA_WIDTH-1:0] instr_data;
  logic [ADDR_WIDTH-1:0] instr_pc;

  modport master (
    output mem_wr_en, mem_rd_en, mem_data_in, mem_addr,
    input  mem_data_out,
    output instr_valid, instr_data, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  mem_wr_en, mem_rd_en, mem_data_in, mem_addr,
    output mem_data_out,
    input  instr_valid, instr_data, instr_pc,
    output instr_ready
  );
endinterface

// File: rtl/mem_fetch_ctrl_skid_buf.sv
// fetch_skid_buf: 2-entry FIFO of {pc, word} between memory response and decode.
//   clk, rst        : clock, async active-high reset
//   flush           : drop all entries (wins over push/pop)
//   push, push_pc/data : write one entry
//   pop             : consume head (caller guarantees occ != 0)
//   head_pc/data    : current head entry
//   occ             : number of valid entries (0..2)
module fetch_skid_buf #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic [ADDR_WIDTH-1:0] push_pc,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [ADDR_WIDTH-1:0] head_pc,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [1:0]            occ
);

  logic [1:0][ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [1:0][DATA_WIDTH-1:0] word_q, word_d;
  logic                       wr_ptr_q, wr_ptr_d;
  logic                       rd_ptr_q, rd_ptr_d;
  logic [1:0]                 occ_q, occ_d;

  always_comb begin
    pc_d     = pc_q;
    word_d   = word_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      occ_d    = '0;
    end else begin
      if (push) begin
        pc_d[wr_ptr_q]   = push_pc;
        word_d[wr_ptr_q] = push_data;
        wr_ptr_d         = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      occ_d = occ_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= '0;
      word_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= '0;
    end else begin
      pc_q     <= pc_d;
      word_q   <= word_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign head_pc   = pc_q[rd_ptr_q];
  assign head_data = word_q[rd_ptr_q];
  assign occ       = occ_q;

endmodule

// File: rtl/mem_fetch_ctrl.sv
// mem_fetch_ctrl: sequential word fetcher for a synchronous memory with a
// 1-cycle read latency, delivering {pc, word} over a valid/ready stream.
//   clk, rst          : clock, async active-high reset
//   start             : begin fetching at START_PC (IDLE only)
//   halt              : stop issuing, drain buffered words, return to IDLE
//   redir_valid/pc    : flush and restart at redir_pc (low 2 bits ignored)
//   bus (master)      : memory bus and instruction stream
//   busy              : controller not in IDLE
// Optional macro FETCH_LOADER_EN adds a preload path (ld_valid, ld_ready,
// ld_data, ld_last) that writes words to address 0,4,8,... before fetching.
module mem_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned MEM_DEPTH  = 20,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = $clog2(MEM_DEPTH) + 2,
  parameter int unsigned START_PC   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  halt,
  input  logic                  redir_valid,
  input  logic [ADDR_WIDTH-1:0] redir_pc,
  mem_fetch_ctrl_if.master      bus,
`ifdef FETCH_LOADER_EN
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  ld_last,
`endif
  output logic                  busy
);

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(PC_STEP);
  localparam logic [ADDR_WIDTH-1:0] WRAP_PC    = ADDR_WIDTH'(pc_wrap_limit(MEM_DEPTH));
  localparam logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(START_PC);
  localparam logic [ADDR_WIDTH-1:0] START_ADDR = RESET_PC & ALIGN_MASK;

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
    return (a == WRAP_PC) ? '0 : a + STEP;
  endfunction

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
`ifdef FETCH_LOADER_EN
  logic [ADDR_WIDTH-1:0] ld_addr_q, ld_addr_d;
`endif

  logic                  rd_en;
  logic                  wr_en;
  logic                  redir_take;
  logic                  push;
  logic                  pop;
  logic                  instr_valid;
  logic [1:0]            occ;
  logic [2:0]            credit;
  logic [ADDR_WIDTH-1:0] head_pc;
  logic [DATA_WIDTH-1:0] head_data;

  assign instr_valid = (occ != 2'd0);
  assign pop         = instr_valid & bus.instr_ready;
  // Words already owed to the buffer after this cycle's pop; at most 2 fit.
  assign credit      = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, pop};

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    rd_en         = 1'b0;
    wr_en         = 1'b0;
    redir_take    = 1'b0;
`ifdef FETCH_LOADER_EN
    ld_addr_d     = ld_addr_q;
    ld_ready      = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          pc_d    = START_ADDR;
        end
`ifdef FETCH_LOADER_EN
        else if (ld_valid) begin
          state_d   = LOAD;
          ld_addr_d = '0;
        end
`endif
      end
      FETCH: begin
        // Halt outranks redirect; a redirect cycle issues nothing so no
        // old-PC read can slip past the squash.
        if (halt) begin
          state_d = DRAIN;
        end else if (redir_valid) begin
          redir_take = 1'b1;
          pc_d       = redir_pc & ALIGN_MASK;
        end else if (credit < 3'd2) begin
          rd_en         = 1'b1;
          pc_d          = next_addr(pc_q);
          inflight_d    = 1'b1;
          inflight_pc_d = pc_q;
        end
      end
      DRAIN: begin
        // Leave as the last word is popped so busy drops the following cycle.
        if (!inflight_q && (occ == 2'd0 || (occ == 2'd1 && pop))) begin
          state_d = IDLE;
        end
      end
      LOAD: begin
`ifdef FETCH_LOADER_EN
        ld_ready = 1'b1;
        wr_en    = ld_valid;
        if (ld_valid) begin
          ld_addr_d = next_addr(ld_addr_q);
          if (ld_last) begin
            state_d = IDLE;
          end
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // An outstanding response lands in the buffer unless a redirect squashes it.
  assign push = inflight_q & ~redir_take;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

`ifdef FETCH_LOADER_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_addr_q <= '0;
    end else begin
      ld_addr_q <= ld_addr_d;
    end
  end
`endif

  fetch_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (redir_take),
    .push      (push),
    .push_pc   (inflight_pc_q),
    .push_data (bus.mem_data_out),
    .pop       (pop),
    .head_pc   (head_pc),
    .head_data (head_data),
    .occ       (occ)
  );

  assign bus.mem_rd_en   = rd_en;
  assign bus.mem_wr_en   = wr_en;
`ifdef FETCH_LOADER_EN
  assign bus.mem_addr    = rd_en ? pc_q : (wr_en ? ld_addr_q : '0);
  assign bus.mem_data_in = wr_en ? ld_data : '0;
`else
  assign bus.mem_addr    = rd_en ? pc_q : '0;
  assign bus.mem_data_in = '0;
`endif
  assign bus.instr_valid = instr_valid;
  assign bus.instr_pc    = instr_valid ? head_pc : '0;
  assign bus.instr_data  = instr_valid ? head_data : '0;
  assign busy            = (state_q != IDLE);

endmodule
